// File: rtl/fpga_id_pkg.sv
// Shared types and constants for the FPGA identification ROM reader.
package fpga_id_pkg;

    typedef enum logic [1:0] {
        SCAN_ISSUE = 2'd0,
        SCAN_WAIT  = 2'd1,
        IDLE       = 2'd2,
        RD_WAIT    = 2'd3
    } fpga_id_rd_state_t;

    localparam logic [31:0] FPGA_ID_MAGIC          = 32'h4554_4F4E;
    localparam int          FPGA_ID_RD_LATENCY_DEF = 2;

    // Width of a down-counter that must hold RD_LATENCY-1.
    function automatic int lat_cnt_width(input int rd_latency);
        return $clog2(rd_latency + 1);
    endfunction

endpackage

// File: rtl/fpga_id_rd_seq.sv
// Single ROM read sequencer: registers the address on start and flags the
// cycle in which rom_rd_data is valid, RD_LATENCY clocks after start.
module fpga_id_rd_seq
    import fpga_id_pkg::*;
#(
    parameter int A_WIDTH    = 8,
    parameter int RD_LATENCY = FPGA_ID_RD_LATENCY_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [A_WIDTH-1:0] addr,
    output logic [A_WIDTH-1:0] rom_rd_addr,
    output logic               data_valid
);

    localparam int CW = lat_cnt_width(RD_LATENCY);

    logic [CW-1:0] cnt;
    logic          busy;

    // A new start always wins, so a caller can re-issue without draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_rd_addr <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
        end else if (start) begin
            rom_rd_addr <= addr;
            cnt         <= CW'(RD_LATENCY - 1);
            busy        <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) busy <= 1'b0;
            else           cnt  <= cnt - 1'b1;
        end
    end

    assign data_valid = busy && (cnt == '0);

endmodule

// File: rtl/fpga_id_reader.sv
// Scans the ID ROM after reset (magic check + checksum), then serves
// single-word CPU reads through an Avalon-MM slave port.
module fpga_id_reader
    import fpga_id_pkg::*;
#(
    parameter int                 D_WIDTH    = 32,
    parameter int                 A_WIDTH    = 8,
    parameter int                 RD_LATENCY = FPGA_ID_RD_LATENCY_DEF,
    parameter int                 SCAN_WORDS = 16,
    parameter logic [D_WIDTH-1:0] MAGIC      = D_WIDTH'(FPGA_ID_MAGIC)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    output logic [A_WIDTH-1:0] rom_rd_addr_o,
    input  logic [D_WIDTH-1:0] rom_rd_data_i,
    input  logic [A_WIDTH-1:0] amm_address_i,
    input  logic               amm_read_i,
    output logic               amm_waitrequest_o,
    output logic [D_WIDTH-1:0] amm_readdata_o,
    output logic               amm_readdatavalid_o,
    input  logic               rescan_i,
    output logic               scan_done_o,
    output logic               id_valid_o,
    output logic [D_WIDTH-1:0] checksum_o,
    output fpga_id_rd_state_t  dbg_state_o
);

    localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(SCAN_WORDS - 1);

    fpga_id_rd_state_t  state;
    logic [A_WIDTH-1:0] index;
    logic [D_WIDTH-1:0] acc;
    logic               magic_hit;
    logic               rescan_pend;
    logic               seq_start;
    logic [A_WIDTH-1:0] seq_addr;
    logic               seq_valid;
    logic               last_word;
    logic               word_match;

    assign last_word   = (index == LAST_IDX);
    assign word_match  = (rom_rd_data_i == MAGIC);
    assign dbg_state_o = state;

    // Avalon handshake: a read is accepted on a clock edge where amm_read_i is
    // high and amm_waitrequest_o was low during the preceding cycle; the data
    // follows as a single-cycle amm_readdatavalid_o pulse.
    always_comb begin
        seq_start = 1'b0;
        seq_addr  = index;
        unique case (state)
            SCAN_ISSUE: seq_start = 1'b1;
            SCAN_WAIT: begin
                seq_start = seq_valid && !last_word && !rescan_i;
                seq_addr  = index + 1'b1;
            end
            IDLE: begin
                seq_start = amm_read_i && !rescan_i;
                seq_addr  = amm_address_i;
            end
            default: seq_start = 1'b0;
        endcase
    end

    fpga_id_rd_seq #(
        .A_WIDTH    (A_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_seq (
        .clk         (clk_i),
        .rst_n       (rst_n_i),
        .start       (seq_start),
        .addr        (seq_addr),
        .rom_rd_addr (rom_rd_addr_o),
        .data_valid  (seq_valid)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state               <= SCAN_ISSUE;
            index               <= '0;
            acc                 <= '0;
            magic_hit           <= 1'b0;
            rescan_pend         <= 1'b0;
            amm_waitrequest_o   <= 1'b1;
            amm_readdata_o      <= '0;
            amm_readdatavalid_o <= 1'b0;
            scan_done_o         <= 1'b0;
            id_valid_o          <= 1'b0;
            checksum_o          <= '0;
        end else begin
            amm_readdatavalid_o <= 1'b0;
            unique case (state)
                SCAN_ISSUE: begin
                    scan_done_o <= 1'b0;
                    rescan_pend <= 1'b0;
                    state       <= SCAN_WAIT;
                end
                SCAN_WAIT: begin
                    if (rescan_i) begin
                        state <= SCAN_ISSUE;
                        index <= '0;
                        acc   <= '0;
                    end else if (seq_valid) begin
                        acc <= acc + rom_rd_data_i;
                        if (index == '0) magic_hit <= word_match;
                        if (last_word) begin
                            // Published results only change here, so they stay stable during a rescan.
                            state             <= IDLE;
                            amm_waitrequest_o <= 1'b0;
                            scan_done_o       <= 1'b1;
                            checksum_o        <= acc + rom_rd_data_i;
                            id_valid_o        <= (index == '0) ? word_match : magic_hit;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (rescan_i) begin
                        state             <= SCAN_ISSUE;
                        index             <= '0;
                        acc               <= '0;
                        amm_waitrequest_o <= 1'b1;
                    end else if (amm_read_i) begin
                        state             <= RD_WAIT;
                        amm_waitrequest_o <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (rescan_i) rescan_pend <= 1'b1;
                    if (seq_valid) begin
                        amm_readdata_o      <= rom_rd_data_i;
                        amm_readdatavalid_o <= 1'b1;
                        if (rescan_pend || rescan_i) begin
                            state <= SCAN_ISSUE;
                            index <= '0;
                            acc   <= '0;
                        end else begin
                            state             <= IDLE;
                            amm_waitrequest_o <= 1'b0;
                        end
                    end
                end
                default: state <= SCAN_ISSUE;
            endcase
        end
    end

endmodule
